// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM state encoding,
// bus widths, and the address error check.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Misaligned or beyond the array; no aliasing of high addresses.
    function automatic logic is_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           Clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [STRB_W-1:0]              wstrb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < STRB_W; i++) begin
                    if (wstrb[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready request intake, programmable wait
// latency, then a held response carrying read data or an error flag.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state, state_next;
    logic [3:0]        cnt;
    logic              accept, commit;
    logic              lat_write;
    logic [WORD_W-1:0] lat_addr, lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;
    logic              cur_write, cur_err;
    logic [WORD_W-1:0] cur_addr, cur_wdata;
    logic [STRB_W-1:0] cur_wstrb;
    logic              err_q, rd_q;
    logic [WORD_W-1:0] arr_rdata;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero latency the commit edge is the acceptance edge, so the live
    // request must be used before it has been latched.
    assign cur_write = (state == IDLE) ? req_write : lat_write;
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;
    assign cur_err   = is_err(cur_addr, DEPTH_WORDS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                cnt       <= WAIT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q <= cur_err;
                rd_q  <= !cur_err && !cur_write;
            end else if (state == RESP && resp_ready) begin
                err_q <= 1'b0;
                rd_q  <= 1'b0;
            end
        end
    end

    // Reset on the commit edge must leave the RAM untouched.
    mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .Clk   (Clk),
        .en    (commit && !Reset && !cur_err),
        .we    (cur_write),
        .wstrb (cur_wstrb),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign resp_err   = err_q;
    assign resp_rdata = rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: LATENCY=2 instance against a word-array model with
// directed and random traffic, plus a LATENCY=0 instance for timing/throughput.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [3:0]  a_req_wstrb = '0;
    logic        a_resp_valid, a_resp_ready = 1'b0, a_resp_err;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_wstrb = '0;
    logic        b_resp_valid, b_resp_ready = 1'b0, b_resp_err;
    logic [31:0] b_resp_rdata;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .Clk(clk), .Reset(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
        .Clk(clk), .Reset(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] model [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rv(input bit b);
        return b ? b_resp_valid : a_resp_valid;
    endfunction
    function automatic logic rr(input bit b);
        return b ? b_req_ready : a_req_ready;
    endfunction
    function automatic logic [31:0] rd_of(input bit b);
        return b ? b_resp_rdata : a_resp_rdata;
    endfunction
    function automatic logic er_of(input bit b);
        return b ? b_resp_err : a_resp_err;
    endfunction

    task automatic set_req(input bit b, input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (b) begin
            b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = d; b_req_wstrb = s;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = d; a_req_wstrb = s;
        end
    endtask

    task automatic set_rresp(input bit b, input logic v);
        if (b) b_resp_ready = v;
        else   a_resp_ready = v;
    endtask

    // One full transaction; lat counts cycles from the acceptance edge to resp_valid.
    task automatic txn(input bit b, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        set_req(b, 1'b1, w, a, d, s);
        while (!rr(b) && n < 20) begin step(); n++; end
        step();
        set_req(b, 1'b0, 1'b0, '0, '0, '0);
        lat = 1;
        while (!rv(b) && lat < 40) begin step(); lat++; end
        rd = rd_of(b);
        er = er_of(b);
        set_rresp(b, 1'b1);
        step();
        set_rresp(b, 1'b0);
    endtask

    task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string tag, output logic [31:0] rd);
        logic        er;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        int unsigned idx;
        idx     = a >> 2;
        exp_err = (a % 4 != 0) || (a >= 32'd1024);
        exp_rd  = (!exp_err && !w) ? model[idx] : 32'h0;
        txn(1'b0, w, a, d, s, rd, er, lat);
        check({tag, ".lat"}, 32'(lat), 32'd3);
        check({tag, ".err"}, 32'(er), 32'(exp_err));
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".ready"}, 32'(a_req_ready), 32'd1);
        if (w && !exp_err) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] held;
        int          r;
        logic [31:0] addr;

        rst = 1'b1;
        step();
        step();
        check("rst.resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst.resp_err", 32'(a_resp_err), 32'd0);
        check("rst.resp_rdata", a_resp_rdata, 32'd0);
        rst = 1'b0;
        check("rst.req_ready", 32'(a_req_ready), 32'd1);
        check("rst.req_ready_b", 32'(b_req_ready), 32'd1);

        for (int i = 0; i < 256; i++) begin
            model[i] = $urandom;
            txn(1'b0, 1'b1, 32'(i * 4), model[i], 4'hF, rd, er, lat);
        end

        model_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10", rd);
        model_txn(1'b0, 32'h10, 32'h0, 4'h0, "rd10", rd);
        check("rd10.const", rd, 32'hDEADBEEF);

        model_txn(1'b1, 32'h20, 32'h11223344, 4'hF, "wr20", rd);
        model_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "wr20p", rd);
        model_txn(1'b0, 32'h20, 32'h0, 4'hF, "rd20", rd);
        check("rd20.const", rd, 32'h11BB33DD);

        model_txn(1'b0, 32'h13, 32'h0, 4'h0, "rd13", rd);
        model_txn(1'b0, 32'h400, 32'h0, 4'h0, "rd400", rd);
        model_txn(1'b1, 32'h400, 32'h99999999, 4'hF, "wr400", rd);
        model_txn(1'b0, 32'h0, 32'h0, 4'h0, "rd0", rd);
        model_txn(1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, "wrlast", rd);
        model_txn(1'b0, 32'h3FC, 32'h0, 4'h0, "rdlast", rd);

        model_txn(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, "wr30z", rd);
        model_txn(1'b0, 32'h30, 32'h0, 4'hF, "rd30", rd);

        // Response back-pressure with a competing request held on the bus.
        set_req(1'b0, 1'b1, 1'b0, 32'h10, '0, '0);
        step();
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        lat = 1;
        while (!a_resp_valid && lat < 40) begin step(); lat++; end
        check("stall.lat", 32'(lat), 32'd3);
        held = model[4];
        set_req(1'b0, 1'b1, 1'b1, 32'h14, 32'h12345678, 4'hF);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d.valid", k), 32'(a_resp_valid), 32'd1);
            check($sformatf("stall%0d.rdata", k), a_resp_rdata, held);
            check($sformatf("stall%0d.req_ready", k), 32'(a_req_ready), 32'd0);
            step();
        end
        a_resp_ready = 1'b1;
        step();
        check("stall.release_ready", 32'(a_req_ready), 32'd1);
        check("stall.release_valid", 32'(a_resp_valid), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        a_resp_ready = 1'b0;
        step();
        model_txn(1'b0, 32'h14, 32'h0, 4'h0, "rd14", rd);

        // Reset landing on the commit edge of a write.
        model_txn(1'b1, 32'h8, 32'h0, 4'hF, "wr8", rd);
        set_req(1'b0, 1'b1, 1'b1, 32'h8, 32'h55, 4'hF);
        step();
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        rst = 1'b1;
        step();
        check("abort.resp_valid", 32'(a_resp_valid), 32'd0);
        rst = 1'b0;
        check("abort.req_ready", 32'(a_req_ready), 32'd1);
        step();
        check("abort.no_resp", 32'(a_resp_valid), 32'd0);
        model_txn(1'b0, 32'h8, 32'h0, 4'h0, "rd8", rd);
        check("rd8.const", rd, 32'h0);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr = {22'h0, 8'($urandom), 2'b00};
            else if (r == 7) addr = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (r == 8) addr = 32'h400 + {18'h0, 12'($urandom) & 12'hFFC};
            else             addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            model_txn(1'($urandom), addr, $urandom, 4'($urandom), $sformatf("rnd%0d", i), rd);
        end

        txn(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, rd, er, lat);
        check("l0.wr.lat", 32'(lat), 32'd1);
        check("l0.wr.rdata", rd, 32'h0);
        check("l0.wr.err", 32'(er), 32'd0);
        txn(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        check("l0.rd.lat", 32'(lat), 32'd1);
        check("l0.rd.rdata", rd, 32'hCAFEF00D);
        txn(1'b1, 1'b0, 32'h401, 32'h0, 4'h0, rd, er, lat);
        check("l0.err.err", 32'(er), 32'd1);

        set_req(1'b1, 1'b1, 1'b0, 32'h4, '0, '0);
        b_resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("l0.b2b%0d.valid", k), 32'(b_resp_valid), 32'(k % 2 == 0));
            if (k % 2 == 0) check($sformatf("l0.b2b%0d.rdata", k), b_resp_rdata, 32'hCAFEF00D);
        end
        set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        b_resp_ready = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory port; the CPU control path issues read/write requests, this block answers them.
- Holds a word-organised RAM.
- Accepts one request at a time through a valid/ready handshake, inserts a programmable wait latency, then returns a response.
- Errors are flagged on misalignment or out-of-range addresses.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, >= 2)
- LATENCY, 2, wait cycles between request acceptance and response (0..15)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte-lane enables for writes; lane i covers bits 8i+7:8i
- resp_valid  out  1  response available
- resp_ready  in  1  initiator accepts the response
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset, synchronous with priority over everything:
  - state returns to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - req_ready is 1 in the first cycle after reset.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE; resp_valid=1 only in RESP.
- IDLE:
  - Acceptance happens on a rising edge with req_valid&&req_ready; req_write, req_addr, req_wdata and req_wstrb are latched.
  - If LATENCY=0, go directly to RESP. Otherwise go to WAIT with counter=LATENCY-1.
- WAIT: counter decrements each cycle; at counter=0 the next edge enters RESP.
- Transaction commit, on the edge that enters RESP:
  - Error when latched addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS: resp_err=1, resp_rdata=0, RAM untouched.
  - Read: resp_rdata=RAM[addr[31:2]], resp_err=0.
  - Write: only enabled lanes are updated; resp_rdata=0, resp_err=0.
  - wstrb=4'b0000 on a write: RAM unchanged, normal response returned.
  - wstrb is ignored on reads.
- Latency: resp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable until resp_valid&&resp_ready.
  - On that edge: go to IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - A new request can be accepted no earlier than the following edge, so minimum throughput is one transaction per LATENCY+2 cycles.
- Request inputs are ignored outside IDLE; the initiator must hold req_valid until accepted.
- Read after write to the same word returns the new data.
- Reset during WAIT or RESP aborts the transaction and no response is produced. A write whose commit edge coincides with Reset does not modify RAM.
- Address wrap: none. Addresses at or above DEPTH_WORDS*4 always give an error, never an alias.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - WORD_W=32, STRB_W=4
  - function is_err(addr, depth)
- Sub-module mem_array: single-port synchronous word RAM.
  - Ports: Clk, we, wstrb, waddr/raddr index, wdata, rdata.
  - Read data registered on the commit edge.
- mem_responder contains the FSM, wait counter, request latch and error check.

Test Plan:
- LATENCY=2. Write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> write resp_valid 3 cycles after accept with err=0, rdata=0; read returns 0xDEADBEEF.
- Word 0x20 holds 0x11223344. Write 0xAABBCCDD with wstrb 4'b0101, then read 0x20 -> 0x11BB33DD.
- Read 0x13 (misaligned) and read 0x400 (DEPTH_WORDS=256) -> resp_err=1, rdata=0. Write to 0x400 -> err=1, and word 0 is unchanged.
- Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata stay stable. Present a second req_valid meanwhile -> req_ready=0 and it is not accepted. Raise resp_ready -> req_ready=1 on the next cycle.
- Assert Reset on the commit edge of a write of 0x55 to 0x8 (previously 0x0) -> no response, req_ready=1 after reset, a read of 0x8 returns 0x0.
- LATENCY=0 build: read accepted -> resp_valid on the very next cycle. Back-to-back reads with resp_ready=1 -> one transaction per 2 cycles.
